// File: rtl/rv_core_pkg.sv
// Shared types and constants for the fetch front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default PC width, default reset PC, the NOP encoding that fills
// an empty instruction slot, and the fetch FSM state type.
package rv_core_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic {
    S_REQ  = 1'b0,   // request presented to imem
    S_WAIT = 1'b1    // request accepted, awaiting its single response
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry (inst, inst_pc) holding register between fetch and decode.
// Latency: a load is visible on the outputs the cycle after the load edge.
// Backpressure: out_valid stays up and data holds until out_ready; flush drops the entry.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               drop any held entry (wins over load and consume)
//   load, load_inst/pc  write a new entry; may coincide with a consume
//   out_ready           downstream accepts the held entry this cycle
//   out_valid/inst/pc   held entry; inst reads as NOP and pc as 0 after reset
module fetch_out_buf
  import rv_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            load,
  input  logic [31:0]     load_inst,
  input  logic [XLEN-1:0] load_pc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_inst  <= NOP_INST;
      out_pc    <= '0;
    end else begin
      // A load on the same edge as a consume replaces the old entry, so
      // valid only falls when the entry leaves with nothing behind it.
      if (flush) begin
        out_valid <= 1'b0;
      end else if (load) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (load && !flush) begin
        out_inst <= load_inst;
        out_pc   <= load_pc;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Owns the PC, fetches from imem one request at a time and hands (inst, inst_pc) to decode.
// Latency: request accept -> inst_valid = imem response latency + 1; redirect -> imem_addr next cycle.
// Backpressure: no new request while the output buffer is full and decode is not taking it.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   pc_sel, target_pc               redirect from the branch controller (target low bits ignored)
//   imem_req_valid/ready, imem_addr fetch request channel (addr is the current PC)
//   imem_rsp_valid, imem_rsp_data   valid-only response, one per accepted request
//   inst_valid/ready, inst, inst_pc decode channel
//   redirect_cnt, squash_cnt        saturating event counters, present only with FETCH_PERF_EN
//
// A redirect while a request is in flight marks that response for squashing
// rather than cancelling the request, since imem always returns exactly one
// response per accepted request.
module fetch_unit #(
  parameter int                XLEN     = rv_core_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_PC = rv_core_pkg::RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] target_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     squash_cnt
`endif
);

  import rv_core_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;   // PC of the request in flight
  logic            squash_q, squash_d;   // in-flight response is wrong-path
  logic            load;
  logic [XLEN-1:0] target_aligned;

  assign target_aligned = target_pc & ~XLEN'(3);
  assign imem_addr      = pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      squash_q <= squash_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    squash_d       = squash_q;
    imem_req_valid = 1'b0;
    load           = 1'b0;

    case (state_q)
      S_REQ: begin
        // Only ask when the buffer is guaranteed free by the response edge.
        imem_req_valid = !reset && (!inst_valid || inst_ready);
        if (imem_req_valid && imem_req_ready) begin
          state_d  = S_WAIT;
          pc_d     = pc_q + XLEN'(4);
          req_pc_d = pc_q;
          squash_d = pc_sel;   // redirected while being accepted
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d  = S_REQ;
          squash_d = 1'b0;
          load     = !squash_q && !pc_sel;
        end else if (pc_sel) begin
          squash_d = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (pc_sel) begin
      pc_d = target_aligned;
    end
  end

  fetch_out_buf #(.XLEN(XLEN)) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (pc_sel),
    .load      (load),
    .load_inst (imem_rsp_data),
    .load_pc   (req_pc_q),
    .out_ready (inst_ready),
    .out_valid (inst_valid),
    .out_inst  (inst),
    .out_pc    (inst_pc)
  );

`ifdef FETCH_PERF_EN
  logic discard;
  assign discard = (state_q == S_WAIT) && imem_rsp_valid && (squash_q || pc_sel);

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_cnt <= '0;
      squash_cnt   <= '0;
    end else begin
      if (pc_sel && (redirect_cnt != 32'hFFFF_FFFF)) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
      if (discard && (squash_cnt != 32'hFFFF_FFFF)) begin
        squash_cnt <= squash_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural imem, reference model and decode scoreboard.
// Latency: n/a (testbench).
// Backpressure: drives imem_req_ready and inst_ready both directed and randomly.
module tb_fetch_unit;
  import rv_core_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_sel;
  logic [31:0] target_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] redirect_cnt;
  logic [31:0] squash_cnt;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .pc_sel         (pc_sel),
    .target_pc      (target_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef FETCH_PERF_EN
    ,
    .redirect_cnt   (redirect_cnt),
    .squash_cnt     (squash_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction word imem returns for a given address.
  function automatic logic [31:0] mk_data(input logic [31:0] a);
    logic [31:0] r;
    r = {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    return r;
  endfunction

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  // Reference model of the fetch unit; sbq holds what decode should see.
  exp_t        sbq[$];
  logic        m_state;      // 0 = requesting, 1 = waiting
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  logic        m_squash;
  logic        chk_en = 1'b0;
  int          m_redir = 0;
  int          m_sq = 0;

  // Behavioural instruction memory.
  logic        pend = 1'b0;
  int          pcnt = 0;
  logic [31:0] paddr = '0;
  int          rsp_lat = 1;

  task automatic step();
    logic        mreq, hs, rsp, hs_dut;
    logic [31:0] a_dut;
    exp_t        e;
    @(negedge clk);
    mreq = !reset && (m_state == 1'b0) && (sbq.size() == 0 || inst_ready);
    if (chk_en) begin
      check("req_valid", {31'b0, imem_req_valid}, {31'b0, mreq});
      if (mreq) check("imem_addr", imem_addr, m_pc);
      check("inst_valid", {31'b0, inst_valid}, {31'b0, sbq.size() != 0});
      if (sbq.size() != 0 && inst_valid) begin
        check("inst", inst, sbq[0].inst);
        check("inst_pc", inst_pc, sbq[0].pc);
      end
    end
    hs     = mreq && imem_req_ready;
    rsp    = !reset && (m_state == 1'b1) && imem_rsp_valid;
    hs_dut = imem_req_valid && imem_req_ready;
    a_dut  = imem_addr;
    if (reset) begin
      m_state  = 1'b0;
      m_pc     = RESET_PC_DEFAULT;
      m_req_pc = '0;
      m_squash = 1'b0;
      sbq.delete();
      m_redir  = 0;
      m_sq     = 0;
      chk_en   = 1'b1;
    end else begin
      if (sbq.size() != 0 && inst_ready) void'(sbq.pop_front());
      if (pc_sel) begin
        sbq.delete();
        m_redir++;
      end else if (rsp && !m_squash) begin
        e.inst = mk_data(m_req_pc);
        e.pc   = m_req_pc;
        sbq.push_back(e);
      end
      if (rsp && (m_squash || pc_sel)) m_sq++;
      if (m_state == 1'b0) begin
        if (hs) begin
          m_state  = 1'b1;
          m_req_pc = m_pc;
          m_squash = pc_sel;
          m_pc     = m_pc + 32'd4;
        end
      end else if (rsp) begin
        m_state  = 1'b0;
        m_squash = 1'b0;
      end else if (pc_sel) begin
        m_squash = 1'b1;
      end
      if (pc_sel) m_pc = target_pc & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (hs_dut) begin
      pend  = 1'b1;
      pcnt  = rsp_lat;
      paddr = a_dut;
    end
    if (pend) begin
      pcnt--;
      if (pcnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mk_data(paddr);
        pend           = 1'b0;
      end
    end
  endtask

  task automatic wait_inst(input string tag);
    int n = 0;
    while (!inst_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, "_wait"}, {31'b0, inst_valid}, 32'd1);
  endtask

  task automatic wait_state(input string tag, input logic st, input logic want_rsp);
    int n = 0;
    while (!(m_state == st && imem_rsp_valid == want_rsp) && n < 40) begin
      step();
      n++;
    end
    check({tag, "_wait"}, {30'b0, m_state, imem_rsp_valid}, {30'b0, st, want_rsp});
  endtask

  logic [31:0] sv_inst, sv_pc;

  initial begin
    reset          = 1'b1;
    pc_sel         = 1'b0;
    target_pc      = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b1;

    // Reset values, then first request on the cycle after release.
    step();
    step();
    check("rst_inst", inst, NOP_INST);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    reset = 1'b0;
    #1;
    check("first_req", {31'b0, imem_req_valid}, 32'd1);
    check("first_addr", imem_addr, 32'h0);

    // Sequential stream: 0x0, 0x4, 0x8.
    for (int i = 0; i < 3; i++) begin
      wait_inst("seq");
      check("seq_pc", inst_pc, 32'(i * 4));
      step();
    end

    // Decode stalls: no new request and the held entry must not move.
    inst_ready = 1'b0;
    wait_inst("hold");
    sv_inst = inst;
    sv_pc   = inst_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_req", {31'b0, imem_req_valid}, 32'd0);
      check("hold_inst", inst, sv_inst);
      check("hold_pc", inst_pc, sv_pc);
    end
    inst_ready = 1'b1;
    step();

    // Redirect while waiting, response arrives the cycle after.
    rsp_lat = 2;
    wait_state("s3", 1'b1, 1'b0);
    pc_sel    = 1'b1;
    target_pc = 32'h0000_0100;
    step();
    pc_sel = 1'b0;
    for (int n = 0; n < 10 && !imem_req_valid; n++) step();
    check("redir_addr", imem_addr, 32'h0000_0100);
    wait_inst("s3");
    check("s3_inst_pc", inst_pc, 32'h0000_0100);
    check("s3_inst", inst, mk_data(32'h0000_0100));
    step();

    // Redirect on the same edge as the response; target low bits dropped.
    rsp_lat = 1;
    wait_state("s4", 1'b1, 1'b1);
    pc_sel    = 1'b1;
    target_pc = 32'h0000_0203;
    step();
    pc_sel = 1'b0;
    check("flush_valid", {31'b0, inst_valid}, 32'd0);
    check("redir_addr2", imem_addr, 32'h0000_0200);
    wait_inst("s4");
    check("s4_inst_pc", inst_pc, 32'h0000_0200);
    step();

    // PC wrap at the top of the address space.
    wait_state("s5", 1'b0, 1'b0);
    imem_req_ready = 1'b0;
    pc_sel         = 1'b1;
    target_pc      = 32'hFFFF_FFFC;
    step();
    pc_sel         = 1'b0;
    imem_req_ready = 1'b1;
    check("wrap_redir", imem_addr, 32'hFFFF_FFFC);
    wait_inst("wrap");
    check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0000_0000);
    step();

`ifdef FETCH_PERF_EN
    check("redirect_cnt", redirect_cnt, 32'd3);
    check("squash_cnt", squash_cnt, 32'd2);
`endif

    // Random traffic with backpressure on both sides and random redirects.
    for (int i = 0; i < 400; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      rsp_lat        = $urandom_range(1, 3);
      pc_sel         = ($urandom_range(0, 15) == 0);
      target_pc      = $urandom;
      step();
    end
    pc_sel         = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    step();
`ifdef FETCH_PERF_EN
    check("rand_redirect_cnt", redirect_cnt, 32'(m_redir));
    check("rand_squash_cnt", squash_cnt, 32'(m_sq));
`endif

    // Reset while a fetch is outstanding; its response lands during reset.
    rsp_lat = 2;
    wait_state("s7", 1'b1, 1'b0);
    reset = 1'b1;
    step();
`ifdef FETCH_PERF_EN
    check("rst_redirect_cnt", redirect_cnt, 32'd0);
    check("rst_squash_cnt", squash_cnt, 32'd0);
`endif
    step();
    reset = 1'b0;
    wait_inst("post_rst");
    check("post_rst_pc", inst_pc, 32'h0);
    check("post_rst_inst", inst, mk_data(32'h0));
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
